// File: rtl/execute_mem_if.sv
// Issue, data-memory and writeback/broadcast signal bundle for the memory execution unit.
// The master modport is the execution unit; the slave modport is its environment.
interface execute_mem_if #(
  parameter int unsigned PRF_INDEX_SIZE = 6,
  parameter int unsigned XLEN           = 32
);
  logic                      issue_valid;
  logic                      issue_is_store;
  logic [1:0]                issue_size;
  logic                      issue_unsigned;
  logic [XLEN-1:0]           issue_rs1_data;
  logic [XLEN-1:0]           issue_rs2_data;
  logic [XLEN-1:0]           issue_imm;
  logic [PRF_INDEX_SIZE-1:0] issue_rd_index;
  logic                      issue_rd_valid;
  logic                      ex_busy;

  logic                      mem_req_valid;
  logic                      mem_req_ready;
  logic [XLEN-1:0]           mem_req_addr;
  logic                      mem_req_wen;
  logic [XLEN-1:0]           mem_req_wdata;
  logic [3:0]                mem_req_wstrb;
  logic                      mem_resp_valid;
  logic [XLEN-1:0]           mem_resp_rdata;

  logic                      wb_valid;
  logic [PRF_INDEX_SIZE-1:0] wb_prf_index;
  logic [XLEN-1:0]           wb_data;
  logic                      ctb_valid;
  logic [PRF_INDEX_SIZE-1:0] ctb_prf_int_index;
  logic                      exc_valid;
  logic [XLEN-1:0]           exc_addr;

  modport master (
    input  issue_valid, issue_is_store, issue_size, issue_unsigned,
           issue_rs1_data, issue_rs2_data, issue_imm, issue_rd_index, issue_rd_valid,
           mem_req_ready, mem_resp_valid, mem_resp_rdata,
    output ex_busy, mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
           wb_valid, wb_prf_index, wb_data, ctb_valid, ctb_prf_int_index, exc_valid, exc_addr
  );

  modport slave (
    output issue_valid, issue_is_store, issue_size, issue_unsigned,
           issue_rs1_data, issue_rs2_data, issue_imm, issue_rd_index, issue_rd_valid,
           mem_req_ready, mem_resp_valid, mem_resp_rdata,
    input  ex_busy, mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wstrb,
           wb_valid, wb_prf_index, wb_data, ctb_valid, ctb_prf_int_index, exc_valid, exc_addr
  );
endinterface

// File: rtl/execute_mem.sv
// Memory execution unit: one outstanding load/store, effective-address generation,
// lane steering for stores, load extraction/extension, writeback and tag broadcast.
module execute_mem #(
  parameter int unsigned PRF_INDEX_SIZE = 6,
  parameter int unsigned XLEN           = 32
) (
  input  logic          clock,
  input  logic          reset,
  execute_mem_if.master bus
);

  typedef enum logic [2:0] {IDLE, REQ, RESP, WB, EXC} state_e;

  state_e                    state_q,    state_d;
  logic                      is_store_q, is_store_d;
  logic [1:0]                size_q,     size_d;
  logic                      unsigned_q, unsigned_d;
  logic [XLEN-1:0]           ea_q,       ea_d;
  logic [XLEN-1:0]           rs2_q,      rs2_d;
  logic [PRF_INDEX_SIZE-1:0] rd_q,       rd_d;
  logic                      rd_valid_q, rd_valid_d;
  logic [XLEN-1:0]           ld_data_q,  ld_data_d;

  logic [XLEN-1:0] issue_ea_c;
  logic            misaligned_c;
  logic [XLEN-1:0] shifted_c;
  logic [XLEN-1:0] ld_ext_c;
  logic [XLEN-1:0] st_wdata_c;
  logic [3:0]      st_wstrb_c;

  // Effective address and alignment of the uop currently offered by the issue queue
  always_comb begin
    issue_ea_c = bus.issue_rs1_data + bus.issue_imm;
    case (bus.issue_size)
      2'b00:   misaligned_c = 1'b0;
      2'b01:   misaligned_c = issue_ea_c[0];
      default: misaligned_c = |issue_ea_c[1:0];
    endcase
  end

  // Load result: bring the addressed lane down to bit 0, then extend by size
  always_comb begin
    shifted_c = bus.mem_resp_rdata >> {ea_q[1:0], 3'b000};
    case (size_q)
      2'b00:   ld_ext_c = {{(XLEN-8){~unsigned_q & shifted_c[7]}}, shifted_c[7:0]};
      2'b01:   ld_ext_c = {{(XLEN-16){~unsigned_q & shifted_c[15]}}, shifted_c[15:0]};
      default: ld_ext_c = shifted_c;
    endcase
  end

  // Store lanes: replicate narrow data across the word, strobe only the addressed bytes
  always_comb begin
    case (size_q)
      2'b00: begin
        st_wdata_c = {(XLEN/8){rs2_q[7:0]}};
        st_wstrb_c = 4'(4'b0001 << ea_q[1:0]);
      end
      2'b01: begin
        st_wdata_c = {(XLEN/16){rs2_q[15:0]}};
        st_wstrb_c = 4'(4'b0011 << ea_q[1:0]);
      end
      default: begin
        st_wdata_c = rs2_q;
        st_wstrb_c = 4'b1111;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      is_store_q <= 1'b0;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      ea_q       <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      rd_valid_q <= 1'b0;
      ld_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      ea_q       <= ea_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      rd_valid_q <= rd_valid_d;
      ld_data_q  <= ld_data_d;
    end
  end

  // Next state; issue and response inputs are only looked at in IDLE and RESP
  always_comb begin
    state_d    = state_q;
    is_store_d = is_store_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    ea_d       = ea_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    rd_valid_d = rd_valid_q;
    ld_data_d  = ld_data_q;
    case (state_q)
      IDLE: begin
        if (bus.issue_valid) begin
          is_store_d = bus.issue_is_store;
          size_d     = bus.issue_size;
          unsigned_d = bus.issue_unsigned;
          ea_d       = issue_ea_c;
          rs2_d      = bus.issue_rs2_data;
          rd_d       = bus.issue_rd_index;
          rd_valid_d = bus.issue_rd_valid;
          state_d    = misaligned_c ? EXC : REQ;
        end
      end
      REQ: begin
        if (bus.mem_req_ready) state_d = RESP;
      end
      RESP: begin
        if (bus.mem_resp_valid) begin
          if (is_store_q) begin
            state_d = IDLE;
          end else begin
            ld_data_d = ld_ext_c;
            state_d   = rd_valid_q ? WB : IDLE;
          end
        end
      end
      WB:      state_d = IDLE;
      EXC:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode from the state register and latched fields only
  always_comb begin
    bus.ex_busy           = (state_q != IDLE);
    bus.mem_req_valid     = 1'b0;
    bus.mem_req_addr      = '0;
    bus.mem_req_wen       = 1'b0;
    bus.mem_req_wdata     = '0;
    bus.mem_req_wstrb     = 4'b0000;
    bus.wb_valid          = 1'b0;
    bus.wb_prf_index      = '0;
    bus.wb_data           = '0;
    bus.ctb_valid         = 1'b0;
    bus.ctb_prf_int_index = '0;
    bus.exc_valid         = 1'b0;
    bus.exc_addr          = '0;
    case (state_q)
      REQ: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_req_addr  = {ea_q[XLEN-1:2], 2'b00};
        bus.mem_req_wen   = is_store_q;
        if (is_store_q) begin
          bus.mem_req_wdata = st_wdata_c;
          bus.mem_req_wstrb = st_wstrb_c;
        end
      end
      WB: begin
        bus.wb_valid          = 1'b1;
        bus.wb_prf_index      = rd_q;
        bus.wb_data           = ld_data_q;
        bus.ctb_valid         = 1'b1;
        bus.ctb_prf_int_index = rd_q;
      end
      EXC: begin
        bus.exc_valid = 1'b1;
        bus.exc_addr  = ea_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_execute_mem.sv
// Self-checking bench for execute_mem: directed scenarios plus randomized loads/stores
// compared against a byte-lane reference model.
module tb_execute_mem;
  localparam int unsigned PW = 6;
  localparam int unsigned XW = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  execute_mem_if #(.PRF_INDEX_SIZE(PW), .XLEN(XW)) bus ();
  execute_mem #(.PRF_INDEX_SIZE(PW), .XLEN(XW)) dut (.clock(clock), .reset(reset), .bus(bus));

  int tests  = 0;
  int failed = 0;

  // Observations collected by drive_txn
  int          o_cycles, o_req_cnt, o_first_req, o_wb_cnt, o_wb_cyc, o_ctb_cnt;
  int          o_exc_cnt, o_exc_cyc, o_busy_cnt;
  bit          o_stable, o_ctb_ok;
  logic [31:0] o_addr, o_wdata, o_wb_data, o_exc_addr;
  logic [3:0]  o_wstrb;
  logic        o_wen;
  logic [5:0]  o_wb_idx;

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit model_misaligned(input logic [1:0] sz, input logic [31:0] ea);
    return (ea % nbytes(sz)) != 0;
  endfunction

  function automatic logic [3:0] model_wstrb(input logic [1:0] sz, input logic [31:0] ea);
    logic [3:0] s = 4'b0000;
    int off = int'(ea % 4);
    for (int i = 0; i < 4; i++) if (i >= off && i < off + nbytes(sz)) s[i] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] rs2);
    logic [31:0] w = 32'h0;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = rs2[8*(i % nbytes(sz)) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [1:0] sz,
                                             input logic uns, input logic [31:0] ea);
    logic [31:0] v = 32'h0;
    int off = int'(ea % 4);
    int n = nbytes(sz);
    for (int k = 0; k < n; k++) v[8*k +: 8] = rdata[8*(off+k) +: 8];
    if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
    return v;
  endfunction

  function automatic int exp_cycles(input bit mis, input logic st, input logic rdv,
                                    input int stall, input int rdly);
    if (mis) return 2;
    return 3 + stall + rdly + ((!st && rdv) ? 1 : 0);
  endfunction

  // Runs one transaction from a negedge with the unit idle; acts as memory and records outputs
  task automatic drive_txn(input logic st, input logic [1:0] sz, input logic uns,
                           input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                           input logic [5:0] rd, input logic rdv, input int stall, input int rdly,
                           input logic [31:0] rdata, input bit poke);
    int  req_idx = 0;
    int  resp_idx = 0;
    bit  done = 0;
    o_cycles = -1; o_req_cnt = 0; o_first_req = -1; o_wb_cnt = 0; o_wb_cyc = -1; o_ctb_cnt = 0;
    o_exc_cnt = 0; o_exc_cyc = -1; o_busy_cnt = 0; o_stable = 1; o_ctb_ok = 1;
    o_addr = 0; o_wdata = 0; o_wb_data = 0; o_exc_addr = 0; o_wstrb = 0; o_wen = 0; o_wb_idx = 0;
    bus.issue_valid = 1'b1; bus.issue_is_store = st; bus.issue_size = sz; bus.issue_unsigned = uns;
    bus.issue_rs1_data = rs1; bus.issue_rs2_data = rs2; bus.issue_imm = imm;
    bus.issue_rd_index = rd; bus.issue_rd_valid = rdv;
    bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0;
    @(negedge clock);
    for (int cyc = 1; cyc <= 64 && !done; cyc++) begin
      bus.mem_req_ready = 1'b0;
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_rdata = $urandom;
      if (poke) begin
        bus.issue_valid = 1'b1; bus.issue_is_store = 1'($urandom); bus.issue_size = 2'($urandom);
        bus.issue_rs1_data = $urandom; bus.issue_rs2_data = $urandom; bus.issue_imm = $urandom;
        bus.issue_rd_index = 6'($urandom); bus.issue_rd_valid = 1'b1; bus.issue_unsigned = 1'($urandom);
      end else begin
        bus.issue_valid = 1'b0;
      end
      if (!bus.ex_busy) begin
        done = 1;
        o_cycles = cyc;
        bus.issue_valid = 1'b0;
      end else begin
        o_busy_cnt++;
        if (bus.mem_req_valid) begin
          if (o_req_cnt == 0) begin
            o_first_req = cyc; o_addr = bus.mem_req_addr; o_wen = bus.mem_req_wen;
            o_wdata = bus.mem_req_wdata; o_wstrb = bus.mem_req_wstrb;
          end else if (o_addr !== bus.mem_req_addr || o_wen !== bus.mem_req_wen ||
                       o_wdata !== bus.mem_req_wdata || o_wstrb !== bus.mem_req_wstrb) begin
            o_stable = 0;
          end
          o_req_cnt++;
          bus.mem_req_ready = (req_idx >= stall);
          req_idx++;
        end
        if (bus.wb_valid) begin
          o_wb_cnt++; o_wb_cyc = cyc; o_wb_idx = bus.wb_prf_index; o_wb_data = bus.wb_data;
          if (!bus.ctb_valid || bus.ctb_prf_int_index !== bus.wb_prf_index) o_ctb_ok = 0;
        end
        if (bus.ctb_valid) o_ctb_cnt++;
        if (bus.exc_valid) begin
          o_exc_cnt++; o_exc_cyc = cyc; o_exc_addr = bus.exc_addr;
        end
        if (o_req_cnt > 0 && !bus.mem_req_valid && !bus.wb_valid && !bus.exc_valid) begin
          if (resp_idx >= rdly) begin
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_rdata = rdata;
          end
          resp_idx++;
        end
        @(negedge clock);
      end
    end
    bus.mem_req_ready = 1'b0;
    bus.mem_resp_valid = 1'b0;
  endtask

  function automatic bit any_output();
    return |{bus.ex_busy, bus.mem_req_valid, bus.mem_req_addr, bus.mem_req_wen, bus.mem_req_wdata,
             bus.mem_req_wstrb, bus.wb_valid, bus.wb_prf_index, bus.wb_data, bus.ctb_valid,
             bus.ctb_prf_int_index, bus.exc_valid, bus.exc_addr};
  endfunction

  task automatic test_reset();
    #1;
    tests++; if (any_output() !== 1'b0) begin failed++; $display("FAIL reset_outputs: some output nonzero, required all 0"); end
    @(negedge clock); reset = 1'b0;
    @(negedge clock);
    tests++; if (bus.ex_busy !== 1'b0) begin failed++; $display("FAIL reset_busy: got %b required 0", bus.ex_busy); end
  endtask

  task automatic test_lw();
    drive_txn(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, 32'h4, 6'd5, 1'b1, 0, 0, 32'hDEADBEEF, 1'b0);
    tests++; if (o_first_req !== 1) begin failed++; $display("FAIL lw_req_cycle: got %0d required 1", o_first_req); end
    tests++; if (o_addr !== 32'h1004 || o_wen !== 1'b0) begin failed++; $display("FAIL lw_req: addr %h wen %b required 00001004/0", o_addr, o_wen); end
    tests++; if (o_wb_cnt !== 1 || o_wb_cyc !== 3) begin failed++; $display("FAIL lw_wb_timing: count %0d cycle %0d required 1/3", o_wb_cnt, o_wb_cyc); end
    tests++; if (o_wb_idx !== 6'd5 || o_wb_data !== 32'hDEADBEEF || !o_ctb_ok || o_ctb_cnt !== 1) begin
      failed++; $display("FAIL lw_wb: idx %0d data %h ctb_ok %0d required 5/deadbeef/1", o_wb_idx, o_wb_data, o_ctb_ok); end
    tests++; if (o_busy_cnt !== 3 || o_cycles !== 4) begin failed++; $display("FAIL lw_busy: busy %0d next_accept %0d required 3/4", o_busy_cnt, o_cycles); end
  endtask

  task automatic test_lb_lbu();
    drive_txn(1'b0, 2'b00, 1'b0, 32'h2000, 32'h0, 32'h3, 6'd9, 1'b1, 0, 0, 32'h80112233, 1'b0);
    tests++; if (o_addr !== 32'h2000 || o_wb_data !== 32'hFFFFFF80) begin failed++; $display("FAIL lb: addr %h data %h required 00002000/ffffff80", o_addr, o_wb_data); end
    drive_txn(1'b0, 2'b00, 1'b1, 32'h2000, 32'h0, 32'h3, 6'd9, 1'b1, 0, 0, 32'h80112233, 1'b0);
    tests++; if (o_wb_data !== 32'h00000080) begin failed++; $display("FAIL lbu: data %h required 00000080", o_wb_data); end
  endtask

  task automatic test_sh();
    drive_txn(1'b1, 2'b01, 1'b0, 32'h3000, 32'h1234ABCD, 32'h2, 6'd3, 1'b1, 0, 0, 32'h0, 1'b0);
    tests++; if (o_addr !== 32'h3000 || o_wstrb !== 4'b1100 || o_wdata !== 32'hABCDABCD || o_wen !== 1'b1) begin
      failed++; $display("FAIL sh_req: addr %h strb %b data %h wen %b required 00003000/1100/abcdabcd/1", o_addr, o_wstrb, o_wdata, o_wen); end
    tests++; if (o_wb_cnt !== 0 || o_ctb_cnt !== 0 || o_cycles !== 3) begin
      failed++; $display("FAIL sh_nowb: wb %0d ctb %0d idle_at %0d required 0/0/3", o_wb_cnt, o_ctb_cnt, o_cycles); end
  endtask

  task automatic test_misaligned();
    drive_txn(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, 32'h1, 6'd4, 1'b1, 0, 0, 32'h0, 1'b0);
    tests++; if (o_exc_cnt !== 1 || o_exc_cyc !== 1 || o_exc_addr !== 32'h1001) begin
      failed++; $display("FAIL misaligned_exc: count %0d cycle %0d addr %h required 1/1/00001001", o_exc_cnt, o_exc_cyc, o_exc_addr); end
    tests++; if (o_req_cnt !== 0 || o_wb_cnt !== 0 || o_cycles !== 2) begin
      failed++; $display("FAIL misaligned_noreq: req %0d wb %0d next_accept %0d required 0/0/2", o_req_cnt, o_wb_cnt, o_cycles); end
  endtask

  task automatic test_stall();
    drive_txn(1'b0, 2'b10, 1'b0, 32'h5000, 32'h0, 32'h8, 6'd12, 1'b1, 3, 1, 32'h0BADF00D, 1'b1);
    tests++; if (o_req_cnt !== 4 || !o_stable || o_addr !== 32'h5008) begin
      failed++; $display("FAIL stall_req: cycles %0d stable %0d addr %h required 4/1/00005008", o_req_cnt, o_stable, o_addr); end
    tests++; if (o_wb_idx !== 6'd12 || o_wb_data !== 32'h0BADF00D || o_cycles !== 8 || o_busy_cnt !== 7) begin
      failed++; $display("FAIL stall_wb: idx %0d data %h next_accept %0d busy %0d required 12/0badf00d/8/7", o_wb_idx, o_wb_data, o_cycles, o_busy_cnt); end
  endtask

  task automatic test_reset_in_resp();
    bit saw_wb = 0;
    bus.issue_valid = 1'b1; bus.issue_is_store = 1'b0; bus.issue_size = 2'b10; bus.issue_unsigned = 1'b0;
    bus.issue_rs1_data = 32'h4000; bus.issue_imm = 32'h0; bus.issue_rd_index = 6'd7; bus.issue_rd_valid = 1'b1;
    @(negedge clock); bus.issue_valid = 1'b0; bus.mem_req_ready = 1'b1;
    @(negedge clock); bus.mem_req_ready = 1'b0;
    tests++; if (bus.ex_busy !== 1'b1 || bus.mem_req_valid !== 1'b0) begin failed++; $display("FAIL rst_resp_state: busy %b req %b required 1/0", bus.ex_busy, bus.mem_req_valid); end
    #2 reset = 1'b1;
    #1;
    tests++; if (any_output() !== 1'b0) begin failed++; $display("FAIL rst_async: some output nonzero, required all 0"); end
    @(negedge clock); reset = 1'b0;
    bus.mem_resp_valid = 1'b1; bus.mem_resp_rdata = 32'h55555555;
    @(negedge clock); bus.mem_resp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (bus.wb_valid || bus.ex_busy) saw_wb = 1;
      @(negedge clock);
    end
    tests++; if (saw_wb !== 1'b0) begin failed++; $display("FAIL rst_late_resp: activity %b required 0", saw_wb); end
    drive_txn(1'b0, 2'b01, 1'b1, 32'h4000, 32'h0, 32'h2, 6'd7, 1'b1, 0, 0, 32'hF00D1234, 1'b0);
    tests++; if (o_wb_data !== 32'h0000F00D || o_wb_idx !== 6'd7) begin failed++; $display("FAIL rst_recover: data %h idx %0d required 0000f00d/7", o_wb_data, o_wb_idx); end
  endtask

  task automatic test_random(input int n);
    for (int t = 0; t < n; t++) begin
      logic st = 1'($urandom);
      logic [1:0] sz = 2'($urandom);
      logic uns = 1'($urandom);
      logic [31:0] rs1 = $urandom & ~32'h3;
      logic [31:0] rs2 = $urandom;
      logic [31:0] off = 32'($urandom_range(0, 3));
      logic [31:0] imm, ea, rdata;
      logic [5:0] rd = 6'($urandom);
      logic rdv = ($urandom_range(0, 3) != 0);
      int stall = $urandom_range(0, 3);
      int rdly = $urandom_range(0, 3);
      bit poke = 1'($urandom);
      bit mis;
      if ($urandom_range(0, 2) != 0) off = off & ~32'(nbytes(sz) - 1);
      imm = ($urandom & ~32'h3) | off;
      ea = rs1 + imm;
      rdata = $urandom;
      mis = model_misaligned(sz, ea);
      drive_txn(st, sz, uns, rs1, rs2, imm, rd, rdv, stall, rdly, rdata, poke);
      tests++; if (o_cycles !== exp_cycles(mis, st, rdv, stall, rdly)) begin
        failed++; $display("FAIL rnd_latency[%0d]: got %0d required %0d", t, o_cycles, exp_cycles(mis, st, rdv, stall, rdly)); end
      tests++; if (o_exc_cnt !== (mis ? 1 : 0) || (mis && o_exc_addr !== ea)) begin
        failed++; $display("FAIL rnd_exc[%0d]: count %0d addr %h required %0d/%h", t, o_exc_cnt, o_exc_addr, mis, ea); end
      tests++; if (o_req_cnt !== (mis ? 0 : stall + 1) || !o_stable) begin
        failed++; $display("FAIL rnd_reqcnt[%0d]: got %0d stable %0d required %0d", t, o_req_cnt, o_stable, mis ? 0 : stall + 1); end
      if (!mis) begin
        tests++; if (o_addr !== (ea & ~32'h3) || o_wen !== st ||
                     o_wstrb !== (st ? model_wstrb(sz, ea) : 4'b0000) ||
                     o_wdata !== (st ? model_wdata(sz, rs2) : 32'h0)) begin
          failed++; $display("FAIL rnd_req[%0d]: addr %h wen %b strb %b data %h required %h/%b/%b/%h", t, o_addr, o_wen, o_wstrb, o_wdata,
                             ea & ~32'h3, st, st ? model_wstrb(sz, ea) : 4'b0000, st ? model_wdata(sz, rs2) : 32'h0); end
      end
      tests++; if (o_wb_cnt !== ((!mis && !st && rdv) ? 1 : 0) || o_ctb_cnt !== o_wb_cnt || !o_ctb_ok) begin
        failed++; $display("FAIL rnd_wbcnt[%0d]: wb %0d ctb %0d required %0d", t, o_wb_cnt, o_ctb_cnt, (!mis && !st && rdv) ? 1 : 0); end
      if (!mis && !st && rdv) begin
        tests++; if (o_wb_idx !== rd || o_wb_data !== model_load(rdata, sz, uns, ea)) begin
          failed++; $display("FAIL rnd_wb[%0d]: idx %0d data %h required %0d/%h", t, o_wb_idx, o_wb_data, rd, model_load(rdata, sz, uns, ea)); end
      end
    end
  endtask

  initial begin
    bus.issue_valid = 1'b0; bus.issue_is_store = 1'b0; bus.issue_size = 2'b00; bus.issue_unsigned = 1'b0;
    bus.issue_rs1_data = '0; bus.issue_rs2_data = '0; bus.issue_imm = '0;
    bus.issue_rd_index = '0; bus.issue_rd_valid = 1'b0;
    bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_resp_rdata = '0;
    reset = 1'b1;
    @(negedge clock);
    test_reset();
    test_lw();
    test_lb_lbu();
    test_sh();
    test_misaligned();
    test_stall();
    test_reset_in_resp();
    test_random(200);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
